// File: rtl/wca_dac_interleaver.sv
// wca_dac_interleaver: buffers packed {Q,I} IF samples in a small FIFO and
// emits them as interleaved 12-bit I/Q word pairs for a dual-channel DAC,
// paced by strobe_dac. Handles priming, underflow/overflow, mute and format.
module wca_dac_interleaver #(
  parameter int FIFO_AW     = 2,
  parameter int PRIME_LEVEL = 2
) (
  input  logic               clock,
  input  logic               ngreset,
  input  logic               enable,
  input  logic [3:0]         cfg,
  input  logic               strobe_if,
  input  logic [23:0]        iq_in,
  input  logic               strobe_dac,
  output logic [11:0]        dac_data,
  output logic               dac_iqsel,
  output logic               dac_wr,
  output logic [FIFO_AW:0]   fifo_level,
  output logic               overflow,
  output logic               underflow,
  output logic [7:0]         underflow_cnt
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_LVL  = DEPTH[FIFO_AW:0];
  localparam logic [FIFO_AW:0] PRIME_LVL = PRIME_LEVEL[FIFO_AW:0];

  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_RUN, S_EMIT2} state_t;

  state_t             state_q;
  logic [23:0]        mem_q [DEPTH];
  logic [FIFO_AW:0]   wr_ptr_q, rd_ptr_q, level;
  logic               empty, full, pop, push, uf_evt, ovf_evt;
  logic [11:0]        zero_w, first_raw, second_raw, word1_d, word2_d;
  logic [23:0]        head;
  logic [11:0]        data_q, hold_q;
  logic               iqsel_q, wr_q, zero_q, hold_zero_q, sw_q, uf_pair_q;
  logic               ovf_q, udf_q;
  logic [7:0]         ucnt_q;

  // Apply mute / offset-binary to a raw two's complement word.
  function automatic logic [11:0] fmt(input logic [11:0] raw, input logic ob, input logic mute);
    if (mute) return {ob, 11'b0};
    return {raw[11] ^ ob, raw[10:0]};
  endfunction

  assign level   = wr_ptr_q - rd_ptr_q;
  assign empty   = (level == '0);
  assign full    = (level == FULL_LVL);
  assign pop     = enable && (state_q == S_RUN) && strobe_dac && !empty;
  assign uf_evt  = enable && (state_q == S_RUN) && strobe_dac && empty;
  // A same-cycle pop frees the slot, so a write into a full FIFO is accepted then.
  assign push    = enable && strobe_if && (!full || pop);
  assign ovf_evt = enable && strobe_if && full && !pop;
  assign zero_w  = {cfg[1], 11'b0};

  // Head-of-FIFO split into emission order, and formatted output words.
  always_comb begin
    head       = mem_q[rd_ptr_q[FIFO_AW-1:0]];
    first_raw  = cfg[0] ? head[23:12] : head[11:0];
    second_raw = cfg[0] ? head[11:0]  : head[23:12];
    word1_d    = empty ? zero_w : fmt(first_raw, cfg[1], cfg[2]);
    word2_d    = hold_zero_q ? zero_w : fmt(hold_q, cfg[1], cfg[2]);
  end

  // FIFO storage; no reset needed, occupancy is tracked by the pointers.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= iq_in;
  end

  // Control FSM, FIFO pointers and registered DAC outputs.
  always_ff @(posedge clock or negedge ngreset) begin
    if (!ngreset) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      data_q      <= '0;
      hold_q      <= '0;
      iqsel_q     <= 1'b0;
      wr_q        <= 1'b0;
      zero_q      <= 1'b1;
      hold_zero_q <= 1'b0;
      sw_q        <= 1'b0;
      uf_pair_q   <= 1'b0;
    end else begin
      wr_q <= 1'b0;
      if (!enable) begin
        // Flush and abandon any pair in progress.
        state_q  <= S_IDLE;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        zero_q   <= 1'b1;
        iqsel_q  <= 1'b0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        case (state_q)
          S_IDLE:  state_q <= S_PRIME;
          S_PRIME: if (level >= PRIME_LVL) state_q <= S_RUN;
          S_RUN: begin
            if (strobe_dac) begin
              data_q      <= word1_d;
              iqsel_q     <= cfg[0];
              wr_q        <= 1'b1;
              zero_q      <= 1'b0;
              hold_q      <= second_raw;
              hold_zero_q <= empty;
              sw_q        <= cfg[0];
              uf_pair_q   <= empty;
              state_q     <= S_EMIT2;
            end
          end
          S_EMIT2: begin
            data_q  <= word2_d;
            iqsel_q <= ~sw_q;
            wr_q    <= 1'b1;
            state_q <= uf_pair_q ? S_PRIME : S_RUN;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  // Sticky status; a new event in the clear cycle takes priority.
  always_ff @(posedge clock or negedge ngreset) begin
    if (!ngreset) begin
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
      ucnt_q <= '0;
    end else begin
      if (ovf_evt)     ovf_q <= 1'b1;
      else if (cfg[3]) ovf_q <= 1'b0;
      if (uf_evt) begin
        udf_q <= 1'b1;
        if (cfg[3])               ucnt_q <= 8'd1;
        else if (ucnt_q != 8'hFF) ucnt_q <= ucnt_q + 8'd1;
      end else if (cfg[3]) begin
        udf_q  <= 1'b0;
        ucnt_q <= '0;
      end
    end
  end

  // While idle the output tracks ZERO in the current format.
  assign dac_data      = zero_q ? zero_w : data_q;
  assign dac_iqsel     = iqsel_q;
  assign dac_wr        = wr_q;
  assign fifo_level    = level;
  assign overflow      = ovf_q;
  assign underflow     = udf_q;
  assign underflow_cnt = ucnt_q;

endmodule

// File: tb/tb_wca_dac_interleaver.sv
// Directed bench for wca_dac_interleaver with a scoreboard queue of expected
// DAC words checked by an independent output monitor.
module tb_wca_dac_interleaver;

  logic        clock = 1'b0;
  logic        ngreset = 1'b0;
  logic        enable = 1'b0;
  logic [3:0]  cfg = 4'h0;
  logic        strobe_if = 1'b0;
  logic [23:0] iq_in = '0;
  logic        strobe_dac = 1'b0;
  logic [11:0] dac_data;
  logic        dac_iqsel, dac_wr, overflow, underflow;
  logic [2:0]  fifo_level;
  logic [7:0]  underflow_cnt;

  int n_chk = 0;
  int n_pass = 0;
  logic [12:0] exp_q[$];   // {iqsel, data}

  wca_dac_interleaver #(.FIFO_AW(2), .PRIME_LEVEL(2)) dut (
    .clock(clock), .ngreset(ngreset), .enable(enable), .cfg(cfg),
    .strobe_if(strobe_if), .iq_in(iq_in), .strobe_dac(strobe_dac),
    .dac_data(dac_data), .dac_iqsel(dac_iqsel), .dac_wr(dac_wr),
    .fifo_level(fifo_level), .overflow(overflow), .underflow(underflow),
    .underflow_cnt(underflow_cnt)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: every DAC write must match the head of the scoreboard.
  always @(negedge clock) begin
    if (ngreset && dac_wr) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_dac_wr: got %0h/%0b expected no write", dac_data, dac_iqsel);
      end else begin
        logic [12:0] e;
        e = exp_q.pop_front();
        check("dac_word", {19'b0, dac_iqsel, dac_data}, {19'b0, e});
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [23:0] s);
    @(posedge clock); #1 strobe_if = 1'b1; iq_in = s;
    @(posedge clock); #1 strobe_if = 1'b0;
  endtask

  task automatic dac();
    @(posedge clock); #1 strobe_dac = 1'b1;
    @(posedge clock); #1 strobe_dac = 1'b0;
  endtask

  task automatic expect_pair(input logic [11:0] w1, input logic s1, input logic [11:0] w2, input logic s2);
    exp_q.push_back({s1, w1});
    exp_q.push_back({s2, w2});
  endtask

  logic [23:0] smp [5];

  initial begin
    // Reset state
    #3;
    check("rst_data", dac_data, 12'h000);
    check("rst_iqsel", dac_iqsel, 1'b0);
    check("rst_wr", dac_wr, 1'b0);
    check("rst_level", fifo_level, 3'd0);
    check("rst_flags", {overflow, underflow, underflow_cnt}, 10'h0);
    @(posedge clock); #1 ngreset = 1'b1; enable = 1'b1;

    // Basic pair: I then Q
    push(24'h123_456); push(24'h123_456); cyc(2);
    expect_pair(12'h456, 1'b0, 12'h123, 1'b1);
    dac(); cyc(2);
    check("t1_level", fifo_level, 3'd1);

    // Swap + offset binary
    cfg = 4'h3;
    push(24'h7FF_800); cyc(1);
    expect_pair(12'h923, 1'b1, 12'hC56, 1'b0); dac();
    expect_pair(12'hFFF, 1'b1, 12'h000, 1'b0); dac();
    // Mute with offset binary -> mid-scale
    push(24'hABC_DEF); cfg = 4'h7;
    expect_pair(12'h800, 1'b1, 12'h800, 1'b0); dac(); cyc(1);
    cfg = 4'h0;
    check("mute_level", fifo_level, 3'd0);

    // Underflow: ZERO pair, then re-prime needs two samples
    expect_pair(12'h000, 1'b0, 12'h000, 1'b1); dac(); cyc(1);
    check("uf_flag", underflow, 1'b1);
    check("uf_cnt1", underflow_cnt, 8'd1);
    push(24'h111_222); cyc(2); dac(); cyc(2);
    check("prime_ignore_cnt", underflow_cnt, 8'd1);
    check("prime_level1", fifo_level, 3'd1);
    push(24'h333_444); cyc(2);
    expect_pair(12'h222, 1'b0, 12'h111, 1'b1); dac();
    expect_pair(12'h444, 1'b0, 12'h333, 1'b1); dac();

    // Saturating underflow count
    for (int i = 0; i < 300; i++) begin
      expect_pair(12'h000, 1'b0, 12'h000, 1'b1); dac();
      push(24'h5A5_A5A); push(24'h5A5_A5A); cyc(2);
      expect_pair(12'hA5A, 1'b0, 12'h5A5, 1'b1); dac();
      expect_pair(12'hA5A, 1'b0, 12'h5A5, 1'b1); dac();
    end
    cyc(1);
    check("uf_cnt_sat", underflow_cnt, 8'd255);

    // Full FIFO with simultaneous write and read
    smp[0] = 24'h100_200; smp[1] = 24'h101_201; smp[2] = 24'h102_202;
    smp[3] = 24'h103_203; smp[4] = 24'h104_204;
    for (int i = 0; i < 4; i++) push(smp[i]);
    check("full_level", fifo_level, 3'd4);
    expect_pair(12'h200, 1'b0, 12'h100, 1'b1);
    @(posedge clock); #1 strobe_if = 1'b1; strobe_dac = 1'b1; iq_in = smp[4];
    @(posedge clock); #1 strobe_if = 1'b0; strobe_dac = 1'b0;
    cyc(2);
    check("simul_level", fifo_level, 3'd4);
    check("simul_no_ovf", overflow, 1'b0);
    expect_pair(12'h201, 1'b0, 12'h101, 1'b1); dac();
    expect_pair(12'h202, 1'b0, 12'h102, 1'b1); dac();
    expect_pair(12'h203, 1'b0, 12'h103, 1'b1); dac();
    expect_pair(12'h204, 1'b0, 12'h104, 1'b1); dac();

    // Overflow: fifth sample dropped and never emitted
    smp[0] = 24'h300_400; smp[1] = 24'h301_401; smp[2] = 24'h302_402;
    smp[3] = 24'h303_403; smp[4] = 24'h3FF_4FF;
    for (int i = 0; i < 5; i++) push(smp[i]);
    check("ovf_level", fifo_level, 3'd4);
    check("ovf_flag", overflow, 1'b1);
    expect_pair(12'h400, 1'b0, 12'h300, 1'b1); dac();
    expect_pair(12'h401, 1'b0, 12'h301, 1'b1); dac();
    expect_pair(12'h402, 1'b0, 12'h302, 1'b1); dac();
    expect_pair(12'h403, 1'b0, 12'h303, 1'b1); dac();
    expect_pair(12'h000, 1'b0, 12'h000, 1'b1); dac(); cyc(1);
    check("ovf_drained", fifo_level, 3'd0);

    // Status clear
    @(posedge clock); #1 cfg = 4'h8;
    @(posedge clock); #1 cfg = 4'h0;
    check("clr_flags", {overflow, underflow, underflow_cnt}, 10'h0);

    // Async reset in the middle of a pair
    push(24'h321_654); push(24'h321_654); cyc(2);
    exp_q.push_back({1'b0, 12'h654});
    @(posedge clock); #1 strobe_dac = 1'b1;
    @(posedge clock); #1 strobe_dac = 1'b0;
    @(negedge clock); #1 ngreset = 1'b0;
    #1;
    check("mid_rst_wr", dac_wr, 1'b0);
    check("mid_rst_data", dac_data, 12'h000);
    check("mid_rst_iqsel", dac_iqsel, 1'b0);
    check("mid_rst_level", fifo_level, 3'd0);
    cfg = 4'h2; #1;
    check("rst_zero_ob", dac_data, 12'h800);
    cfg = 4'h0;

    // Disable flushes the FIFO
    @(posedge clock); #1 ngreset = 1'b1;
    push(24'h0AA_0BB);
    check("pre_flush_level", fifo_level, 3'd1);
    enable = 1'b0; cyc(1);
    check("flush_level", fifo_level, 3'd0);
    check("flush_data", dac_data, 12'h000);

    cyc(4);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Safety net against a hung run.
  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
